s_divider: RTL and testbench

- Iterative signed integer divider; the inverse operation of s_multiplier in the ALU.
- Shares the s_multiplier operand width (WIDTH+1 bits, signed) and the in_valid/out_valid style.
- Sits beside u_add_sub and s_multiplier in the ALU datapath.
- Computes one quotient bit per cycle with a restoring shift-subtract loop on magnitudes, then applies a sign fix-up.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/s_divider_if.sv | 28 ++
 rtl/s_divider.sv | 168 ++++++++++++++++
 tb/tb_s_divider.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU divider types: FSM state encoding and iteration-counter sizing.
package alu_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_N     = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FIXUP,
        DONE
    } div_state_t;

    // Counter must hold N-1, the first quotient bit index.
    function automatic int unsigned div_cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DIV_CNT_W = div_cnt_w(DIV_N);

endpackage

// File: rtl/s_divider_if.sv
// Operand/result handshake bundle for the signed divider (WIDTH+1-bit operands).
interface s_divider_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    localparam int unsigned N = WIDTH + 1;

    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    logic signed [N-1:0] quot;
    logic signed [N-1:0] rem;
    logic                div_by_zero;
    logic                out_valid;

    modport master (
        output in_valid, a, b,
        input  in_ready, quot, rem, div_by_zero, out_valid
    );

    modport slave (
        input  in_valid, a, b,
        output in_ready, quot, rem, div_by_zero, out_valid
    );

endinterface

// File: rtl/s_divider.sv
// Iterative restoring signed divider: one quotient bit per cycle on magnitudes, then sign fix-up.
// Optional macro S_DIVIDER_EARLY_EXIT_EN shortcuts |a| < |b| straight to the result stage.
module s_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    s_divider_if.slave  bus
);

    localparam int unsigned N     = WIDTH + 1;
    localparam int unsigned PRW   = N + 1;
    localparam int unsigned CNT_W = div_cnt_w(N);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     abs_b_q, abs_b_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [PRW-1:0]   pr_q, pr_d;
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dbz_pend_q, dbz_pend_d;

    logic signed [N-1:0] quot_q, quot_d;
    logic signed [N-1:0] rem_q, rem_d;
    logic                dbz_q, dbz_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;

    logic [N-1:0]   abs_a_c;
    logic [N-1:0]   abs_b_c;
    logic [PRW-1:0] trial_c;
    logic [PRW-1:0] b_ext_c;
    logic [PRW-1:0] diff_c;
    logic           ge_c;
    logic [N-1:0]   rem_mag_c;

    // Operand magnitudes; |most-negative| = 2^(N-1) still fits in N unsigned bits.
    always_comb begin
        abs_a_c = bus.a[N-1] ? N'(-bus.a) : N'(bus.a);
        abs_b_c = bus.b[N-1] ? N'(-bus.b) : N'(bus.b);
    end

    // Restoring step: shift next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        trial_c   = PRW'({pr_q, dvd_q[N-1]});
        b_ext_c   = {1'b0, abs_b_q};
        ge_c      = (trial_c >= b_ext_c);
        diff_c    = trial_c - b_ext_c;
        rem_mag_c = N'(pr_q);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        abs_b_d     = abs_b_q;
        dvd_d       = dvd_q;
        pr_d        = pr_q;
        quot_neg_d  = quot_neg_q;
        rem_neg_d   = rem_neg_q;
        dbz_pend_d  = dbz_pend_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dbz_d       = dbz_q;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    abs_b_d    = abs_b_c;
                    dvd_d      = abs_a_c;
                    pr_d       = '0;
                    quot_neg_d = bus.a[N-1] ^ bus.b[N-1];
                    rem_neg_d  = bus.a[N-1];
                    dbz_pend_d = 1'b0;
                    cnt_d      = CNT_W'(N - 1);
                    // Short paths preload the fix-up stage so it yields quot/rem directly.
                    if (bus.b == '0) begin
                        dbz_pend_d = 1'b1;
                        quot_neg_d = 1'b0;
                        dvd_d      = '1;
                        pr_d       = PRW'(abs_a_c);
                        state_d    = FIXUP;
                    end
`ifdef S_DIVIDER_EARLY_EXIT_EN
                    else if (abs_a_c < abs_b_c) begin
                        dvd_d   = '0;
                        pr_d    = PRW'(abs_a_c);
                        state_d = FIXUP;
                    end
`endif
                    else begin
                        state_d = DIVIDE;
                    end
                end
            end

            DIVIDE: begin
                cnt_d = cnt_q - CNT_W'(1);
                pr_d  = ge_c ? diff_c : trial_c;
                dvd_d = {dvd_q[N-2:0], ge_c};
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end
            end

            FIXUP: begin
                quot_d  = quot_neg_q ? N'(-dvd_q) : dvd_q;
                rem_d   = rem_neg_q ? N'(-rem_mag_c) : rem_mag_c;
                dbz_d   = dbz_pend_q;
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            abs_b_q     <= '0;
            dvd_q       <= '0;
            pr_q        <= '0;
            quot_neg_q  <= 1'b0;
            rem_neg_q   <= 1'b0;
            dbz_pend_q  <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            abs_b_q     <= abs_b_d;
            dvd_q       <= dvd_d;
            pr_q        <= pr_d;
            quot_neg_q  <= quot_neg_d;
            rem_neg_q   <= rem_neg_d;
            dbz_pend_q  <= dbz_pend_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.quot        = quot_q;
    assign bus.rem         = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.in_ready    = in_ready_q;

endmodule

// File: tb/tb_s_divider.sv
// Self-checking bench for s_divider: directed sign/boundary cases plus randomized ops vs. an arithmetic model.
module tb_s_divider;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N     = WIDTH + 1;
    localparam int          FULL_LAT = N + 2;
    localparam int          TMO      = 100;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    s_divider_if #(.WIDTH(WIDTH)) bus ();

    s_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [N-1:0] rnd_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return N'(w);
    endfunction

    // Reference: plain 64-bit signed arithmetic; SV '/' truncates toward zero, '%' follows dividend.
    task automatic model(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                         output logic signed [N-1:0] q, output logic signed [N-1:0] r,
                         output logic z, output int lat);
        longint la;
        longint lb;
        longint aa;
        longint ab;
        la = a;
        lb = b;
        aa = (la < 0) ? -la : la;
        ab = (lb < 0) ? -lb : lb;
        if (lb == 0) begin
            q   = '1;
            r   = a;
            z   = 1'b1;
            lat = 2;
        end else begin
            q   = N'(la / lb);
            r   = N'(la % lb);
            z   = 1'b0;
            lat = FULL_LAT;
`ifdef S_DIVIDER_EARLY_EXIT_EN
            if (aa < ab) lat = 2;
`endif
        end
    endtask

    // Issue one op while idle; latency counts the accept edge as 1 up to the edge raising out_valid.
    task automatic run_op(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                          output logic signed [N-1:0] q, output logic signed [N-1:0] r,
                          output logic z, output int lat);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q = bus.quot;
        r = bus.rem;
        z = bus.div_by_zero;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 33'sd10;
        bus.b        = 33'sd2;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.quot !== '0 || bus.rem !== '0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: quot=%0d rem=%0d dbz=%b expected 0/0/0", bus.quot, bus.rem, bus.div_by_zero);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_signs();
        logic signed [N-1:0] ta [4] = '{33'sd100, -33'sd100, 33'sd100, -33'sd100};
        logic signed [N-1:0] tb [4] = '{33'sd7, 33'sd7, -33'sd7, -33'sd7};
        logic signed [N-1:0] tq [4] = '{33'sd14, -33'sd14, -33'sd14, 33'sd14};
        logic signed [N-1:0] tr [4] = '{33'sd2, -33'sd2, 33'sd2, -33'sd2};
        logic signed [N-1:0] q, r;
        logic z;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], q, r, z, lat);
            checks++;
            if (q !== tq[i] || r !== tr[i] || z !== 1'b0) begin
                errors++;
                $display("FAIL signs[%0d]: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=0", i, q, r, z, tq[i], tr[i]);
            end
            checks++;
            if (lat !== FULL_LAT) begin
                errors++;
                $display("FAIL signs_latency[%0d]: got %0d expected %0d", i, lat, FULL_LAT);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL signs_pulse[%0d]: out_valid=%b in_ready=%b expected 0/1", i, bus.out_valid, bus.in_ready);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.quot !== tq[3] || bus.rem !== tr[3]) begin
            errors++;
            $display("FAIL output_hold: got q=%0d r=%0d expected q=%0d r=%0d", bus.quot, bus.rem, tq[3], tr[3]);
        end
    endtask

    task automatic test_div_by_zero();
        logic signed [N-1:0] ta [2];
        logic signed [N-1:0] q, r;
        logic z;
        int lat;
        ta[0] = 33'sd55;
        ta[1] = {1'b1, {(N-1){1'b0}}};
        for (int i = 0; i < 2; i++) begin
            run_op(ta[i], '0, q, r, z, lat);
            checks++;
            if (q !== -33'sd1 || r !== ta[i] || z !== 1'b1) begin
                errors++;
                $display("FAIL div_by_zero[%0d]: got q=%0d r=%0d z=%b expected q=-1 r=%0d z=1", i, q, r, z, ta[i]);
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL div_by_zero_latency[%0d]: got %0d expected 2", i, lat);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_overflow();
        logic signed [N-1:0] mn;
        logic signed [N-1:0] q, r;
        logic z;
        int lat;
        mn = {1'b1, {(N-1){1'b0}}};
        run_op(mn, -33'sd1, q, r, z, lat);
        checks++;
        if (q !== mn || r !== '0 || z !== 1'b0) begin
            errors++;
            $display("FAIL overflow: got q=%0d r=%0d z=%b expected q=%0d r=0 z=0", q, r, z, mn);
        end
        checks++;
        if (lat !== FULL_LAT) begin
            errors++;
            $display("FAIL overflow_latency: got %0d expected %0d", lat, FULL_LAT);
        end
        @(posedge clk);
    endtask

    task automatic test_small_dividend();
        logic signed [N-1:0] q, r;
        logic z;
        int lat;
        int exp_lat;
`ifdef S_DIVIDER_EARLY_EXIT_EN
        exp_lat = 2;
`else
        exp_lat = FULL_LAT;
`endif
        run_op(33'sd5, 33'sd9, q, r, z, lat);
        checks++;
        if (q !== '0 || r !== 33'sd5 || z !== 1'b0) begin
            errors++;
            $display("FAIL small_dividend: got q=%0d r=%0d z=%b expected q=0 r=5 z=0", q, r, z);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL small_dividend_latency: got %0d expected %0d", lat, exp_lat);
        end
        @(posedge clk);
    endtask

    task automatic test_random();
        logic signed [N-1:0] a, b, q, r, eq, er;
        logic z, ez;
        int lat, elat;
        for (int i = 0; i < 30; i++) begin
            a = rnd_word();
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = N'($urandom_range(1, 15));
                2:       b = rnd_word();
                3:       b = 33'sd1;
                default: begin b = rnd_word(); a = N'($urandom_range(0, 1000)); end
            endcase
            if ($urandom_range(0, 1) == 1) b = -b;
            if ($urandom_range(0, 1) == 1) a = -a;
            model(a, b, eq, er, ez, elat);
            run_op(a, b, q, r, z, lat);
            checks++;
            if (q !== eq || r !== er || z !== ez || lat !== elat) begin
                errors++;
                $display("FAIL random[%0d] a=%0d b=%0d: got q=%0d r=%0d z=%b lat=%0d expected q=%0d r=%0d z=%b lat=%0d",
                         i, a, b, q, r, z, lat, eq, er, ez, elat);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_busy_hold();
        logic signed [N-1:0] q0, r0;
        int  pulses;
        bit  busy_bad;
        pulses   = 0;
        busy_bad = 1'b0;
        q0       = '0;
        r0       = '0;
        @(negedge clk);
        bus.a        = 33'sd100;
        bus.b        = 33'sd7;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    q0 = bus.quot;
                    r0 = bus.rem;
                end
            end
            if (c <= N + 1 && bus.in_ready !== 1'b0) busy_bad = 1'b1;
            if (c == N + 2 && bus.in_ready !== 1'b1) busy_bad = 1'b1;
            @(negedge clk);
            bus.a = rnd_word();
            bus.b = N'($urandom_range(1, 50));
        end
        bus.in_valid = 1'b0;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL busy_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (q0 !== 33'sd14 || r0 !== 33'sd2) begin
            errors++;
            $display("FAIL busy_result: got q=%0d r=%0d expected q=14 r=2", q0, r0);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL busy_in_ready: got bad=%b expected 0", busy_bad);
        end
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_drain: in_ready=%b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic signed [N-1:0] q, r;
        logic z;
        int lat;
        bit saw_valid;
        saw_valid = 1'b0;
        @(negedge clk);
        bus.a        = 33'sd100;
        bus.b        = 33'sd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quot !== '0 || bus.rem !== '0
            || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ov=%b rdy=%b q=%0d r=%0d z=%b expected 0/1/0/0/0",
                     bus.out_valid, bus.in_ready, bus.quot, bus.rem, bus.div_by_zero);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL mid_reset_discard: out_valid seen=%b expected 0", saw_valid);
        end
        run_op(33'sd9, 33'sd3, q, r, z, lat);
        checks++;
        if (q !== 33'sd3 || r !== '0 || z !== 1'b0 || lat !== FULL_LAT) begin
            errors++;
            $display("FAIL after_reset_op: got q=%0d r=%0d z=%b lat=%0d expected q=3 r=0 z=0 lat=%0d",
                     q, r, z, lat, FULL_LAT);
        end
        @(posedge clk);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        test_reset();
        test_signs();
        test_div_by_zero();
        test_overflow();
        test_small_dividend();
        test_random();
        test_busy_hold();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
